reg_bank_sequencer: RTL and testbench

REG_BANK_SEQUENCER -- requirements
Module: reg_bank_sequencer

---
 rtl/reg_bank_pkg.sv | 17 +
 rtl/reg_sel_decoder.sv | 22 ++
 rtl/reg_bank_sequencer.sv | 132 +++++++++++++
 tb/tb_reg_bank_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank sequencer: sequencer state
// encoding and the default widths used by the top and its decoder.
package reg_bank_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RSEL = 3'd2,
    RCAP = 3'd3,
    FIN  = 3'd4
  } seq_state_t;

  localparam int DEF_NR_OF_BITS = 8;
  localparam int DEF_NR_OF_REGS = 4;
  localparam int DEF_ADDR_BITS  = 4;

endpackage

// File: rtl/reg_sel_decoder.sv
// Register-select decoder: turns a register index into a one-hot lane
// vector, all zero while the enable is low.
module reg_sel_decoder
  import reg_bank_pkg::*;
#(
  parameter int NrOfRegs = DEF_NR_OF_REGS,
  parameter int AddrBits = DEF_ADDR_BITS
) (
  input  logic                en,
  input  logic [AddrBits-1:0] addr,
  output logic [NrOfRegs-1:0] onehot
);

  // One-hot decode of addr, gated by en.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      onehot[i] = en && (addr == AddrBits'(i));
    end
  end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Host-side sequencer for a bank of Tick-qualified registers sharing one
// write bus (bus_d) and one tri-state read bus (bus_q). A host transaction
// is latched on acceptance; writes hold the target ClockEnable until the
// bank's Tick strobe lands, reads select the register for one settle cycle
// and capture the bus on the next. Out-of-range indices finish at once
// with an error pulse and never touch the bank.
module reg_bank_sequencer
  import reg_bank_pkg::*;
#(
  parameter int NrOfBits = DEF_NR_OF_BITS,
  parameter int NrOfRegs = DEF_NR_OF_REGS,
  parameter int AddrBits = DEF_ADDR_BITS
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req,
  input  logic                we,
  input  logic [AddrBits-1:0] addr,
  input  logic [NrOfBits-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NrOfBits-1:0] rdata,
  output logic [NrOfBits-1:0] bus_d,
  output logic [NrOfRegs-1:0] reg_ce,
  output logic [NrOfRegs-1:0] reg_cs,
  input  logic [NrOfBits-1:0] bus_q
);

  seq_state_t          state;
  logic [AddrBits-1:0] lat_addr;
  logic                ce_en;
  logic                cs_en;
  logic [NrOfRegs-1:0] cs_hot;
  logic                addr_oor;

  // An index past the last implemented register is rejected at acceptance.
  assign addr_oor = (int'(addr) >= NrOfRegs);

  // Sequencer FSM; every output it owns is registered so the bank lanes
  // change only on clock edges (or immediately on Reset).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      bus_d    <= '0;
      lat_addr <= '0;
      ce_en    <= 1'b0;
      cs_en    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= addr;
            bus_d    <= wdata;
            if (addr_oor) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (we) begin
              state <= WR;
              busy  <= 1'b1;
              ce_en <= 1'b1;
            end else begin
              state <= RSEL;
              busy  <= 1'b1;
              cs_en <= 1'b1;
            end
          end
        end
        WR: begin
          // The bank only loads when Tick is high, so the enable is held
          // until a Tick cycle has been seen.
          if (Tick) begin
            state <= FIN;
            busy  <= 1'b0;
            ce_en <= 1'b0;
            done  <= 1'b1;
          end
        end
        RSEL: begin
          // Bus-settle cycle: the selected register is driving bus_q.
          state <= RCAP;
        end
        RCAP: begin
          rdata <= bus_q;
          state <= FIN;
          busy  <= 1'b0;
          cs_en <= 1'b0;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ce_en <= 1'b0;
          cs_en <= 1'b0;
        end
      endcase
    end
  end

  reg_sel_decoder #(
    .NrOfRegs(NrOfRegs),
    .AddrBits(AddrBits)
  ) u_ce_dec (
    .en    (ce_en),
    .addr  (lat_addr),
    .onehot(reg_ce)
  );

  reg_sel_decoder #(
    .NrOfRegs(NrOfRegs),
    .AddrBits(AddrBits)
  ) u_cs_dec (
    .en    (cs_en),
    .addr  (lat_addr),
    .onehot(cs_hot)
  );

  // Output-disable is active-low per lane: only the selected register drives.
  assign reg_cs = ~cs_hot;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: a Tick-qualified register bank model on the
// shared buses, transaction tasks that schedule the expected per-cycle
// outputs, and one negedge compare process.
module tb_reg_bank_sequencer;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int AB = 4;

  logic          Clock, Reset, Tick, req, we;
  logic [AB-1:0] addr;
  logic [NB-1:0] wdata, rdata, bus_d, bus_q;
  logic          busy, done, err;
  logic [NR-1:0] reg_ce, reg_cs;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic [NR-1:0] ce;
    logic [NR-1:0] cs;
    logic [NB-1:0] rdata;
    logic [NB-1:0] busd;
  } rec_t;

  rec_t          exp_q [int];
  logic [NB-1:0] mdl_mem [NR];
  logic [NB-1:0] mdl_rdata;
  logic [NB-1:0] idle_rdata, idle_busd;
  logic [NB-1:0] bank [NR];
  int            total, bad, cyc;
  int            lat, n;

  reg_bank_sequencer #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .bus_d (bus_d),
    .reg_ce(reg_ce),
    .reg_cs(reg_cs),
    .bus_q (bus_q)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Bank registers: load bus_d when their ClockEnable and Tick are both high.
  always @(posedge Clock) begin
    if (Reset) bank <= '{8'h11, 8'h22, 8'h33, 8'h3C};
    else
      for (int i = 0; i < NR; i++)
        if (reg_ce[i] && Tick) bank[i] <= bus_d;
  end

  // Resolved read bus: whichever register has its output enabled drives it.
  always_comb begin
    bus_q = '0;
    for (int i = 0; i < NR; i++)
      if (!reg_cs[i]) bus_q = bank[i];
  end

  function automatic logic [NR-1:0] hot(input int a);
    logic [NR-1:0] h;
    h = '0;
    h[a] = 1'b1;
    return h;
  endfunction

  function automatic rec_t mk(input logic bz, input logic dn, input logic er,
                              input logic [NR-1:0] ce, input logic [NR-1:0] cs,
                              input logic [NB-1:0] rd, input logic [NB-1:0] bd);
    rec_t r;
    r.busy = bz; r.done = dn; r.err = er; r.ce = ce; r.cs = cs;
    r.rdata = rd; r.busd = bd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Per-cycle comparison of all outputs against the scheduled expectation.
  always @(negedge Clock) begin : cmp
    rec_t e;
    if (Reset) begin
      idle_rdata = '0;
      idle_busd  = '0;
    end
    if (!Reset && exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      idle_rdata = e.rdata;
      idle_busd  = e.busd;
    end else begin
      e = mk(1'b0, 1'b0, 1'b0, '0, '1, idle_rdata, idle_busd);
    end
    chk("busy",   32'(busy),   32'(e.busy));
    chk("done",   32'(done),   32'(e.done));
    chk("err",    32'(err),    32'(e.err));
    chk("reg_ce", 32'(reg_ce), 32'(e.ce));
    chk("reg_cs", 32'(reg_cs), 32'(e.cs));
    chk("rdata",  32'(rdata),  32'(e.rdata));
    chk("bus_d",  32'(bus_d),  32'(e.busd));
    total++;
    one_lane: assert ($countones(~reg_cs) <= 1) else begin
      bad++;
      $display("FAIL one_lane: reg_cs=%b has more than one active lane", reg_cs);
    end
    chk("ce_cs_excl", 32'((reg_ce != '0) && (reg_cs != '1)), 32'd0);
  end

  // One clock, then sample: record done latency and active-lane cycle count.
  task automatic step(input int b, inout int l, inout int cnt, input bit use_cs);
    @(posedge Clock);
    #1;
    if (done && l < 0) l = cyc - b;
    if (use_cs ? (reg_cs != '1) : (reg_ce != '0)) cnt++;
  endtask

  task automatic do_write(input int a, input logic [NB-1:0] d, input int k,
                          output int l, output int nce);
    int b;
    b = cyc; l = -1; nce = 0;
    for (int j = 1; j <= k + 1; j++)
      exp_q[b+j] = mk(1'b1, 1'b0, 1'b0, hot(a), '1, mdl_rdata, d);
    exp_q[b+k+2] = mk(1'b0, 1'b1, 1'b0, '0, '1, mdl_rdata, d);
    mdl_mem[a] = d;
    req = 1'b1; we = 1'b1; addr = AB'(a); wdata = d; Tick = 1'b1;
    step(b, l, nce, 1'b0);
    req = 1'b0; we = 1'b0; addr = AB'(a + 1); wdata = ~d;
    for (int j = 0; j < k; j++) begin
      Tick = 1'b0;
      step(b, l, nce, 1'b0);
    end
    Tick = 1'b1;
    step(b, l, nce, 1'b0);
    step(b, l, nce, 1'b0);
  endtask

  task automatic do_read(input int a, input bit poke, output int l, output int ncs);
    int b;
    logic [NB-1:0] junk;
    b = cyc; l = -1; ncs = 0;
    junk = NB'($urandom);
    exp_q[b+1] = mk(1'b1, 1'b0, 1'b0, '0, ~hot(a), mdl_rdata, junk);
    exp_q[b+2] = mk(1'b1, 1'b0, 1'b0, '0, ~hot(a), mdl_rdata, junk);
    exp_q[b+3] = mk(1'b0, 1'b1, 1'b0, '0, '1, mdl_mem[a], junk);
    mdl_rdata = mdl_mem[a];
    req = 1'b1; we = 1'b0; addr = AB'(a); wdata = junk;
    step(b, l, ncs, 1'b1);
    req = poke; we = 1'b1; addr = AB'(a ^ 1); wdata = ~junk;
    step(b, l, ncs, 1'b1);
    step(b, l, ncs, 1'b1);
    req = 1'b0;
    step(b, l, ncs, 1'b1);
  endtask

  task automatic do_err(input int a, input logic w, output int l);
    int b, cnt;
    logic [NB-1:0] d;
    b = cyc; l = -1; cnt = 0;
    d = NB'($urandom);
    exp_q[b+1] = mk(1'b0, 1'b1, 1'b1, '0, '1, mdl_rdata, d);
    req = 1'b1; we = w; addr = AB'(a); wdata = d;
    step(b, l, cnt, 1'b0);
    req = 1'b0;
    step(b, l, cnt, 1'b0);
    chk("err_no_lane", 32'(cnt), 32'd0);
  endtask

  initial begin
    int b;
    Reset = 1'b1; Tick = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mdl_mem = '{8'h11, 8'h22, 8'h33, 8'h3C};
    mdl_rdata = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_busy",  32'(busy),   32'd0);
    chk("rst_done",  32'(done),   32'd0);
    chk("rst_err",   32'(err),    32'd0);
    chk("rst_rdata", 32'(rdata),  32'd0);
    chk("rst_bus_d", 32'(bus_d),  32'd0);
    chk("rst_ce",    32'(reg_ce), 32'h0);
    chk("rst_cs",    32'(reg_cs), 32'hF);
    Reset = 1'b0;

    do_write(2, 8'hA5, 0, lat, n);
    chk("w2_lat", 32'(lat), 32'd2);
    chk("w2_ce_cycles", 32'(n), 32'd1);
    chk("w2_bus_d_hold", 32'(bus_d), 32'hA5);

    do_write(1, 8'h96, 3, lat, n);
    chk("w1_lat", 32'(lat), 32'd5);
    chk("w1_ce_cycles", 32'(n), 32'd4);

    do_read(3, 1'b0, lat, n);
    chk("r3_lat", 32'(lat), 32'd3);
    chk("r3_cs_cycles", 32'(n), 32'd2);
    chk("r3_rdata", 32'(rdata), 32'h3C);

    do_err(7, 1'b0, lat);
    chk("e7_lat", 32'(lat), 32'd1);
    chk("e7_rdata", 32'(rdata), 32'h3C);

    do_read(2, 1'b1, lat, n);
    chk("r2_rdata", 32'(rdata), 32'hA5);
    do_read(1, 1'b0, lat, n);
    chk("r1_rdata", 32'(rdata), 32'h96);

    do_write(0, 8'h0F, 1, lat, n);
    chk("w0_lat", 32'(lat), 32'd3);
    do_err(4, 1'b1, lat);
    do_err(15, 1'b1, lat);
    chk("e15_rdata", 32'(rdata), 32'h96);
    do_write(3, 8'hC3, 2, lat, n);
    do_read(0, 1'b1, lat, n);
    chk("r0_rdata", 32'(rdata), 32'h0F);
    do_read(3, 1'b0, lat, n);
    chk("r3b_rdata", 32'(rdata), 32'hC3);

    // Reset in the middle of a read: lanes drop at once, no done afterwards.
    b = cyc;
    wdata = 8'h77;
    exp_q[b+1] = mk(1'b1, 1'b0, 1'b0, '0, ~hot(1), mdl_rdata, 8'h77);
    req = 1'b1; we = 1'b0; addr = AB'(1);
    @(posedge Clock); #1;
    req = 1'b0;
    #2;
    Reset = 1'b1;
    exp_q.delete();
    mdl_rdata = '0;
    mdl_mem = '{8'h11, 8'h22, 8'h33, 8'h3C};
    #1;
    chk("rsel_rst_cs",    32'(reg_cs), 32'hF);
    chk("rsel_rst_busy",  32'(busy),   32'd0);
    chk("rsel_rst_done",  32'(done),   32'd0);
    chk("rsel_rst_rdata", 32'(rdata),  32'd0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    do_write(0, 8'h5A, 0, lat, n);
    chk("post_rst_lat", 32'(lat), 32'd2);
    do_read(0, 1'b0, lat, n);
    chk("post_rst_rdata", 32'(rdata), 32'h5A);
    do_read(2, 1'b0, lat, n);
    chk("post_rst_r2", 32'(rdata), 32'h33);

    repeat (3) begin
      @(posedge Clock); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
